// File: rtl/obuf_bias_sel_multi_pkg.sv
// Shared types and helpers for the per-buffer obuf bias/destination selector.
// Imported by the top and by every channel instance.
package obuf_sel_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    WR_DDR = 1'b0,
    WR_PE  = 1'b1
  } wr_dst_e;

  // Width needed to address n items, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/obuf_bias_sel_multi_chan.sv
// One output buffer's slice: stride-dependency and status tables, config
// counter with sticky overflow, and the registered bias/destination selects.
module obuf_bias_sel_chan
  import obuf_sel_pkg::*;
#(
  parameter int unsigned LOOP_ID_W = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 busy_i,
  input  logic                 start_acc_i,
  input  logic                 acc_en_i,
  input  logic                 done_i,
  input  logic                 cfg_wr_i,
  input  logic                 cfg_nz_i,
  input  logic                 loop_last_iter_i,
  input  logic                 loop_stall_i,
  input  logic                 loop_enter_i,
  input  logic                 loop_exit_i,
  input  logic                 loop_index_valid_i,
  input  logic [LOOP_ID_W-1:0] loop_index_i,
  input  logic                 enter_dly_i,
  input  logic                 exit_dly_i,
  output logic                 bias_prev_sw_o,
  output logic                 ddr_pe_sw_o,
  output logic                 cfg_overflow_o
);

  localparam int unsigned MAX_LOOPS = 1 << LOOP_ID_W;

  logic [MAX_LOOPS-1:0] dep_q, dep_d;
  logic [MAX_LOOPS-1:0] stat_q, stat_d;
  logic [LOOP_ID_W:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 prev_bias_q, prev_bias_d;
  wr_dst_e              prev_ddr_q, prev_ddr_d;
  logic                 acc_q, acc_d;
  logic                 dep_cur;
  logic                 stat_cur;

  assign dep_cur  = dep_q[loop_index_i];
  assign stat_cur = stat_q[loop_index_i];

  always_comb begin
    cnt_d       = cnt_q;
    dep_d       = dep_q;
    ovf_d       = ovf_q;
    stat_d      = stat_q;
    prev_bias_d = prev_bias_q;
    prev_ddr_d  = prev_ddr_q;
    acc_d       = start_acc_i ? acc_en_i : acc_q;

    // The counter's top bit set means all MAX_LOOPS entries are taken.
    if (done_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (cfg_wr_i) begin
      if (!cnt_q[LOOP_ID_W]) begin
        dep_d[cnt_q[LOOP_ID_W-1:0]] = cfg_nz_i;
        cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (!busy_i) begin
      prev_bias_d = 1'b0;
    end else if (loop_enter_i && exit_dly_i) begin
      prev_bias_d = stat_cur;
    end else if (loop_index_valid_i && !loop_stall_i && !dep_cur) begin
      prev_bias_d = 1'b1;
    end

    if (!busy_i) begin
      stat_d = '0;
    end else if (enter_dly_i) begin
      stat_d[loop_index_i] = prev_bias_q;
    end else if (loop_exit_i && !dep_cur) begin
      stat_d[loop_index_i] = 1'b1;
    end

    if (!busy_i) begin
      prev_ddr_d = WR_PE;
    end else if ((loop_enter_i || loop_index_valid_i) && !dep_cur) begin
      prev_ddr_d = loop_last_iter_i ? WR_PE : WR_DDR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q       <= '0;
      dep_q       <= '0;
      stat_q      <= '0;
      ovf_q       <= 1'b0;
      prev_bias_q <= 1'b0;
      prev_ddr_q  <= WR_PE;
      acc_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dep_q       <= dep_d;
      stat_q      <= stat_d;
      ovf_q       <= ovf_d;
      prev_bias_q <= prev_bias_d;
      prev_ddr_q  <= prev_ddr_d;
      acc_q       <= acc_d;
    end
  end

  assign bias_prev_sw_o = prev_bias_q & acc_q;
  assign ddr_pe_sw_o    = prev_ddr_q;
  assign cfg_overflow_o = ovf_q;

endmodule

// File: rtl/obuf_bias_sel_multi.sv
// Layer FSM and loop enter/exit delay line shared by NUM_BUF channel
// selectors that drive the obuf bias-source and write-destination muxes.
module obuf_bias_sel_multi
  import obuf_sel_pkg::*;
#(
  parameter int unsigned LOOP_ID_W     = 5,
  parameter int unsigned ADDR_STRIDE_W = 16,
  parameter int unsigned NUM_BUF       = 2,
  parameter int unsigned BUF_ID_W      = clog2_min1(NUM_BUF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     done,
  input  logic [NUM_BUF-1:0]       acc_en,
  input  logic [ADDR_STRIDE_W-1:0] obuf_stride,
  input  logic                     obuf_stride_v,
  input  logic [BUF_ID_W-1:0]      obuf_stride_buf,
  input  logic                     loop_last_iter,
  input  logic                     loop_stall,
  input  logic                     loop_enter,
  input  logic                     loop_exit,
  input  logic                     loop_index_valid,
  input  logic [LOOP_ID_W-1:0]     loop_index,
  output logic [NUM_BUF-1:0]       bias_prev_sw,
  output logic [NUM_BUF-1:0]       ddr_pe_sw,
  output logic [NUM_BUF-1:0]       cfg_overflow
);

  state_e state_q, state_d;
  logic   enter_dly_q;
  logic   exit_dly_q;
  logic   busy;
  logic   start_acc;
  logic   stride_nz;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_BUSY;
      ST_BUSY: if (done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      enter_dly_q <= 1'b0;
      exit_dly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      enter_dly_q <= loop_enter;
      exit_dly_q  <= loop_exit;
    end
  end

  assign busy      = (state_q == ST_BUSY);
  assign start_acc = (state_q == ST_IDLE) && start;
  assign stride_nz = |obuf_stride;

  for (genvar b = 0; b < NUM_BUF; b++) begin : g_chan
    logic cfg_wr;
    assign cfg_wr = obuf_stride_v && (obuf_stride_buf == BUF_ID_W'(b));

    obuf_bias_sel_chan #(
      .LOOP_ID_W(LOOP_ID_W)
    ) u_chan (
      .clk_i              (clk),
      .reset_i            (reset),
      .busy_i             (busy),
      .start_acc_i        (start_acc),
      .acc_en_i           (acc_en[b]),
      .done_i             (done),
      .cfg_wr_i           (cfg_wr),
      .cfg_nz_i           (stride_nz),
      .loop_last_iter_i   (loop_last_iter),
      .loop_stall_i       (loop_stall),
      .loop_enter_i       (loop_enter),
      .loop_exit_i        (loop_exit),
      .loop_index_valid_i (loop_index_valid),
      .loop_index_i       (loop_index),
      .enter_dly_i        (enter_dly_q),
      .exit_dly_i         (exit_dly_q),
      .bias_prev_sw_o     (bias_prev_sw[b]),
      .ddr_pe_sw_o        (ddr_pe_sw[b]),
      .cfg_overflow_o     (cfg_overflow[b])
    );
  end

endmodule

// File: doc/obuf_bias_sel_multi.md
# obuf_bias_sel_multi

Per-buffer bias-source and write-destination selector for NUM_BUF output buffers sharing one loop nest. For each buffer it tracks which loops move the obuf address. From that it decides two things: whether the next tile's bias comes from the previous partial sum (obuf) or from the bias buffer, and whether results go to DDR or stay on-chip for the PE. It sits beside the loop controller and feeds the obuf read/write muxes of every output channel. A per-buffer accumulate enable and a config-overflow flag are added.

## Interface
- LOOP_ID_W, 5: loop index width; MAX_LOOPS = 2^LOOP_ID_W table entries per buffer
- ADDR_STRIDE_W, 16: obuf stride width
- NUM_BUF, 2: number of independent output buffers (≥1)
- BUF_ID_W, $clog2(NUM_BUF) min 1: buffer select width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin layer (IDLE→BUSY)
- done  in  1  end layer (BUSY→IDLE); also clears config counters
- acc_en  in  NUM_BUF  per-buffer accumulate enable, latched on accepted start
- obuf_stride  in  ADDR_STRIDE_W  stride of next configured loop
- obuf_stride_v  in  1  stride valid
- obuf_stride_buf  in  BUF_ID_W  target buffer of stride write
- loop_last_iter, loop_stall, loop_enter, loop_exit, loop_index_valid  in  1 each  loop-controller events
- loop_index  in  LOOP_ID_W  currently active loop
- bias_prev_sw  out  NUM_BUF  1 = take bias from obuf partial sum
- ddr_pe_sw  out  NUM_BUF  0 = WR_DDR, 1 = WR_PE
- cfg_overflow  out  NUM_BUF  sticky: stride written beyond MAX_LOOPS

## Operation
- FSM ST_IDLE/ST_BUSY. IDLE→BUSY on start; BUSY→IDLE on done. start in BUSY ignored; done in IDLE ignored.
- Config: per buffer b, a counter cnt[b] (LOOP_ID_W+1 bits).
  - On obuf_stride_v with buf=b and cnt[b]<MAX_LOOPS: dep[b][cnt[b]] ← (obuf_stride≠0), then cnt[b]++.
  - At cnt[b]=MAX_LOOPS the write is dropped and cfg_overflow[b]←1.
  - done clears cnt and cfg_overflow, and takes priority over a same-cycle stride_v.
  - Config is legal in either state.
- Lookups: d = dep[b][loop_index], s = stat[b][loop_index].
- prev_bias[b], evaluated in priority order:
  - not BUSY → 0
  - else loop_enter && exit_dly → s
  - else loop_index_valid && !loop_stall && !d → 1
- stat[b][·]:
  - In IDLE all entries are cleared each cycle.
  - In BUSY, enter_dly → stat[b][loop_index] ← prev_bias[b].
  - Else loop_exit && !d → stat[b][loop_index] ← 1.
- prev_ddr[b]:
  - not BUSY → WR_PE
  - else (loop_enter || loop_index_valid) && !d → loop_last_iter ? WR_PE : WR_DDR
- Outputs:
  - bias_prev_sw[b] = prev_bias[b] & acc_q[b].
  - ddr_pe_sw[b] = prev_ddr[b], which is not gated by acc_q.

## Timing
- All outputs are registered. Every update is visible 1 cycle after the triggering inputs.
- exit_dly and enter_dly are loop_exit and loop_enter delayed by 1 cycle; both reset to 0.
- Reset values:
  - state=IDLE, cnt=0, dep=0, stat=0, acc_q=0
  - bias_prev_sw=0, ddr_pe_sw=all 1, cfg_overflow=0
- Reset mid-BUSY returns to reset values the next cycle. The stride config is lost and must be rewritten.
- acc_q updates only on the IDLE→BUSY transition.
- Simultaneous events:
  - start and done in IDLE → BUSY.
  - stat write and prev_bias update in the same cycle each use the pre-edge values.
  - Stride writes to different buffers need separate cycles.

## Structure
- Package obuf_sel_pkg holds:
  - ST_IDLE=0, ST_BUSY=1
  - WR_DDR=0, WR_PE=1
  - the clog2 helper
- Sub-module obuf_bias_sel_chan holds one buffer's dep/stat tables, cnt, overflow, prev_bias, prev_ddr and acc_q.
- The top holds the FSM and the enter/exit delays, and instantiates NUM_BUF channels with a generate loop.

## Test plan
- Dependency per buffer: write buffer 0 strides {4,0,8} and buffer 1 strides {0,0,2}. Start with acc_en=2'b11. Raise loop_index_valid at index 1 with no stall. → Next cycle bias_prev_sw=2'b11.
- Stride gating: buffer 0 stride at index 2 ≠0 and buffer 1 stride at index 2 ≠0. Raise loop_index_valid at index 2. → bias_prev_sw stays 2'b00.
- DDR destination: with a dependency-free index, pulse loop_enter with loop_last_iter=0. → ddr_pe_sw[b]=0. Repeat with loop_last_iter=1. → ddr_pe_sw[b]=1. On done, ddr_pe_sw returns to 2'b11 one cycle after IDLE is reached.
- Status inherit/set: loop_exit at index 1 (no dependency) sets stat=1. Follow with loop_enter at index 1 in the next cycle. → prev_bias=1. In IDLE, all stat entries read 0.
- Overflow: with LOOP_ID_W=2, write 5 strides to buffer 1. → cfg_overflow=2'b10, and the 5th write does not alter dep[1][0]. done clears the flag.
- Reset and acc gating: assert reset mid-BUSY. → All outputs take reset values next cycle. Separately, start with acc_en=2'b01 under conditions that set both prev_bias. → bias_prev_sw=2'b01.
